// File: rtl/ddr_req_arbiter.sv
// N-channel DDR request arbiter with command FIFO and read-tag FIFO.
// Accepted requests queue here, issue one at a time and return read data to the issuing channel.
module ddr_req_arbiter #(
  parameter int          NUM_CH    = 4,
  parameter int          ADDR_W    = 25,
  parameter int          DATA_W    = 128,
  parameter int          DEPTH     = 16,
  parameter int          TAG_DEPTH = 16,
  parameter int          AF_MARGIN = 2,
  parameter int          ARB_MODE  = 0,
  parameter logic [3:0]  RD_CMD    = 4'b0011,
  parameter logic [3:0]  WR_CMD    = 4'b0100
) (
  input  logic                        clk_133M,
  input  logic                        rst_133M,
  input  logic                        init_done,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [NUM_CH-1:0]           ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]    ch_wdata,
  output logic [NUM_CH-1:0]           ch_ack,
  output logic                        busy,
  input  logic                        cmd_busy,
  output logic [3:0]                  cmd,
  output logic                        cmd_valid,
  output logic [ADDR_W-1:0]           ddr_address,
  output logic [DATA_W-1:0]           ddr_wr_data,
  input  logic                        ddr_data_valid,
  input  logic [DATA_W-1:0]           ddr_rd_data,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_CH-1:0]           rd_valid,
  output logic                        rd_err,
  output logic [$clog2(DEPTH):0]      fifo_count
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(TAG_DEPTH);
  localparam int TCW = TW + 1;

  logic [ADDR_W-1:0] addr_arr [NUM_CH];
  logic [DATA_W-1:0] data_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_arr[i] = ch_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = ch_wdata[i*DATA_W +: DATA_W];
  end

  // Command FIFO storage
  logic              mem_we   [DEPTH];
  logic [CHW-1:0]    mem_ch   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_nx;

  // Read tag FIFO storage
  logic [CHW-1:0]    tag_mem [TAG_DEPTH];
  logic [TW-1:0]     tag_wr, tag_rd;
  logic [TCW-1:0]    tag_count, tag_count_nx;

  logic [CHW-1:0]    rr_ptr;
  logic [CHW-1:0]    gnt_ch;
  logic [CHW-1:0]    sel;
  logic              found;
  logic              push, pop, head_we, tag_full, tag_push, tag_pop;

  // Arbitration: search order is fixed or rotating from the last accepted channel
  always_comb begin
    ch_ack = '0;
    gnt_ch = '0;
    sel    = '0;
    found  = 1'b0;
    if (!rst_133M && init_done && (fifo_count < CW'(DEPTH))) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ARB_MODE == 1)
          sel = CHW'(i);
        else
          sel = CHW'((32'(rr_ptr) + i + 1) % NUM_CH);
        if (!found && ch_req[sel]) begin
          found  = 1'b1;
          gnt_ch = sel;
        end
      end
      if (found)
        ch_ack = NUM_CH'(1) << gnt_ch;
    end
  end

  assign push     = |ch_ack;
  assign head_we  = mem_we[rd_ptr];
  assign tag_full = (tag_count == TCW'(TAG_DEPTH));
  assign pop      = (fifo_count != '0) && init_done && !cmd_busy && !cmd_valid &&
                    !(!head_we && tag_full);
  assign tag_push = pop && !head_we;
  assign tag_pop  = ddr_data_valid && (tag_count != '0);

  always_comb begin
    count_nx = fifo_count;
    if (push && !pop)
      count_nx = fifo_count + 1'b1;
    else if (pop && !push)
      count_nx = fifo_count - 1'b1;
  end

  always_comb begin
    tag_count_nx = tag_count;
    if (tag_push && !tag_pop)
      tag_count_nx = tag_count + 1'b1;
    else if (tag_pop && !tag_push)
      tag_count_nx = tag_count - 1'b1;
  end

  // Storage arrays carry no reset; pointers and counts define validity
  always_ff @(posedge clk_133M) begin
    if (push) begin
      mem_we[wr_ptr]   <= ch_we[gnt_ch];
      mem_ch[wr_ptr]   <= gnt_ch;
      mem_addr[wr_ptr] <= addr_arr[gnt_ch];
      mem_data[wr_ptr] <= ch_we[gnt_ch] ? data_arr[gnt_ch] : '0;
    end
    if (tag_push)
      tag_mem[tag_wr] <= mem_ch[rd_ptr];
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      busy        <= 1'b0;
      rr_ptr      <= CHW'(NUM_CH - 1);
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      ddr_address <= '0;
      ddr_wr_data <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      tag_count   <= '0;
      rd_data     <= '0;
      rd_valid    <= '0;
      rd_err      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= gnt_ch;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_nx;
      busy       <= (count_nx >= CW'(DEPTH - AF_MARGIN));

      cmd_valid <= pop;
      if (pop) begin
        cmd         <= head_we ? WR_CMD : RD_CMD;
        ddr_address <= mem_addr[rd_ptr];
        ddr_wr_data <= mem_data[rd_ptr];
      end

      if (tag_push)
        tag_wr <= tag_wr + 1'b1;
      if (tag_pop)
        tag_rd <= tag_rd + 1'b1;
      tag_count <= tag_count_nx;

      rd_valid <= '0;
      if (ddr_data_valid) begin
        rd_data <= ddr_rd_data;
        if (tag_count == '0)
          rd_err <= 1'b1;
        else
          rd_valid <= NUM_CH'(1) << tag_mem[tag_rd];
      end
    end
  end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Randomized bench for ddr_req_arbiter: round-robin and fixed-priority instances share stimulus
// and are each compared every cycle against a queue-based reference model.
module tb_ddr_req_arbiter;

  localparam int         NCH  = 4;
  localparam int         AW   = 25;
  localparam int         DW   = 128;
  localparam int         DEP  = 16;
  localparam int         TDEP = 2;
  localparam int         AFM  = 2;
  localparam logic [3:0] RDC  = 4'b0011;
  localparam logic [3:0] WRC  = 4'b0100;

  logic clk_133M = 1'b0;
  always #5 clk_133M = ~clk_133M;

  logic              rst_133M, init_done, cmd_busy, ddr_data_valid;
  logic [NCH-1:0]    ch_req, ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     ddr_rd_data;

  logic [NCH-1:0] ack  [2];
  logic           bsy  [2];
  logic [3:0]     cmdo [2];
  logic           cv   [2];
  logic [AW-1:0]  dad  [2];
  logic [DW-1:0]  dwd  [2];
  logic [DW-1:0]  rdo  [2];
  logic [NCH-1:0] rv   [2];
  logic           rerr [2];
  logic [4:0]     fc   [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    ddr_req_arbiter #(
      .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .TAG_DEPTH(TDEP),
      .AF_MARGIN(AFM), .ARB_MODE(m), .RD_CMD(RDC), .WR_CMD(WRC)
    ) u_dut (
      .clk_133M(clk_133M), .rst_133M(rst_133M), .init_done(init_done),
      .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
      .ch_ack(ack[m]), .busy(bsy[m]), .cmd_busy(cmd_busy), .cmd(cmdo[m]),
      .cmd_valid(cv[m]), .ddr_address(dad[m]), .ddr_wr_data(dwd[m]),
      .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data),
      .rd_data(rdo[m]), .rd_valid(rv[m]), .rd_err(rerr[m]), .fifo_count(fc[m])
    );
  end

  typedef struct packed {
    logic          we;
    logic [1:0]    ch;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t           cq [2][$];
  int             tq [2][$];
  int             rr   [2];
  logic           mcv  [2];
  logic [3:0]     mcmd [2];
  logic [AW-1:0]  mad  [2];
  logic [DW-1:0]  mwd  [2];
  logic [NCH-1:0] mrv  [2];
  logic [DW-1:0]  mrd  [2];
  logic           merr [2];
  int             last_g0;
  int             n_vec = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cq[m].delete();
      tq[m].delete();
      rr[m]   = NCH - 1;
      mcv[m]  = 1'b0;
      mcmd[m] = '0;
      mad[m]  = '0;
      mwd[m]  = '0;
      mrv[m]  = '0;
      mrd[m]  = '0;
      merr[m] = 1'b0;
    end
    last_g0 = -1;
  endtask

  // Channel the model expects to be granted this cycle, or -1
  function automatic int pick(int m);
    if (rst_133M || !init_done || cq[m].size() >= DEP) return -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m == 1) ? k : (rr[m] + 1 + k) % NCH;
      if (ch_req[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    #1;
    for (int m = 0; m < 2; m++) begin
      int   g;
      bit   popc;
      ent_t e;
      g = pick(m);
      check($sformatf("ack%0d", m), ack[m], (g < 0) ? '0 : (NCH'(1) << g));
      if (m == 0) last_g0 = g;
      if (!rst_133M) begin
        popc = (cq[m].size() > 0) && init_done && !cmd_busy && !mcv[m] &&
               !(!cq[m][0].we && tq[m].size() >= TDEP);
        mrv[m] = '0;
        if (ddr_data_valid) begin
          mrd[m] = ddr_rd_data;
          if (tq[m].size() > 0) mrv[m] = NCH'(1) << tq[m].pop_front();
          else merr[m] = 1'b1;
        end
        mcv[m] = popc;
        if (popc) begin
          e = cq[m].pop_front();
          mcmd[m] = e.we ? WRC : RDC;
          mad[m]  = e.a;
          mwd[m]  = e.d;
          if (!e.we) tq[m].push_back(int'(e.ch));
        end
        if (g >= 0) begin
          e.we = ch_we[g];
          e.ch = 2'(g);
          e.a  = ch_addr[g*AW +: AW];
          e.d  = ch_we[g] ? ch_wdata[g*DW +: DW] : '0;
          cq[m].push_back(e);
          rr[m] = g;
        end
      end
    end
    @(negedge clk_133M);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("fifo_count%0d", m), fc[m], DW'(cq[m].size()));
      check($sformatf("busy%0d", m), bsy[m], DW'(cq[m].size() >= DEP - AFM));
      check($sformatf("cmd_valid%0d", m), cv[m], mcv[m]);
      check($sformatf("cmd%0d", m), cmdo[m], mcmd[m]);
      check($sformatf("ddr_address%0d", m), dad[m], mad[m]);
      check($sformatf("ddr_wr_data%0d", m), dwd[m], mwd[m]);
      check($sformatf("rd_valid%0d", m), rv[m], mrv[m]);
      check($sformatf("rd_data%0d", m), rdo[m], mrd[m]);
      check($sformatf("rd_err%0d", m), rerr[m], merr[m]);
    end
  endtask

  // Requests stay up until channel is taken by the round-robin instance
  task automatic drive(input int p_req, input int p_busy, input int p_dv, input int p_we);
    for (int c = 0; c < NCH; c++) begin
      if (!ch_req[c] || last_g0 == c) begin
        ch_req[c]              = ($urandom_range(99) < p_req);
        ch_we[c]               = ($urandom_range(99) < p_we);
        ch_addr[c*AW +: AW]    = AW'($urandom);
        ch_wdata[c*DW +: DW]   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    cmd_busy       = ($urandom_range(99) < p_busy);
    ddr_data_valid = (tq[0].size() > 0 || tq[1].size() > 0) && ($urandom_range(99) < p_dv);
    ddr_rd_data    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run(input int n, input int p_req, input int p_busy, input int p_dv, input int p_we);
    for (int i = 0; i < n; i++) begin
      drive(p_req, p_busy, p_dv, p_we);
      step();
    end
  endtask

  initial begin
    rst_133M       = 1'b1;
    init_done      = 1'b0;
    cmd_busy       = 1'b0;
    ddr_data_valid = 1'b0;
    ch_req         = '0;
    ch_we          = '0;
    ch_addr        = '0;
    ch_wdata       = '0;
    ddr_rd_data    = '0;
    model_reset();
    @(negedge clk_133M);
    step();
    rst_133M = 1'b0;
    step();

    run(10, 80, 0, 0, 50);
    init_done = 1'b1;
    run(300, 50, 30, 40, 50);
    run(25, 100, 100, 0, 100);
    run(60, 0, 0, 50, 50);
    run(16, 100, 0, 50, 50);
    run(300, 60, 20, 15, 20);

    // Asynchronous reset with entries queued
    run(8, 100, 100, 0, 50);
    #2 rst_133M = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_ack%0d", m), ack[m], '0);
      check($sformatf("rst_fifo_count%0d", m), fc[m], '0);
      check($sformatf("rst_busy%0d", m), bsy[m], '0);
      check($sformatf("rst_cmd_valid%0d", m), cv[m], '0);
      check($sformatf("rst_cmd%0d", m), cmdo[m], '0);
      check($sformatf("rst_addr%0d", m), dad[m], '0);
      check($sformatf("rst_wr_data%0d", m), dwd[m], '0);
      check($sformatf("rst_rd_valid%0d", m), rv[m], '0);
      check($sformatf("rst_rd_data%0d", m), rdo[m], '0);
      check($sformatf("rst_rd_err%0d", m), rerr[m], '0);
    end
    model_reset();
    @(negedge clk_133M);
    ch_req   = '0;
    cmd_busy = 1'b0;
    rst_133M = 1'b0;
    step();

    run(300, 50, 25, 30, 40);
    run(80, 0, 0, 60, 50);
    ch_req         = '0;
    ddr_data_valid = 1'b1;
    ddr_rd_data    = {$urandom, $urandom, $urandom, $urandom};
    step();
    ddr_data_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
